filter_result_writer: RTL and testbench
=======================================

Name: filter_result_writer

Overview:
Write-side counterpart to the sample RAM reader. Captures the 105-bit accumulator stream produced by `filtering` (`data_out`/`data_ready`) and scales and saturates each result to a 16-bit signed sample. Writes the samples sequentially into the result RAM, addresses 0..DEPTH-1. It is started by `controller` and reports busy/done back to it, closing the read → filter → write loop.

Parameters:
- ACC_W, 105: width of the filter accumulator input.
- SAMPLE_W, 16: width of the written sample, signed two's complement.
- ADDR_W, 14: result RAM address width.
- DEPTH, 16384: samples per run; must be ≤ 2^ADDR_W.
- FRAC_SHIFT, 15: arithmetic right shift applied to the accumulator (coefficient fraction bits).
- DISCARD, 0: number of leading filter outputs dropped (pipeline fill transient).

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle pulse from `controller`; begins a run.
- in_valid, in, 1: filter `data_ready`; in_data is valid this cycle.
- in_data, in, ACC_W: filter accumulator output, signed.
- wr_en, out, 1: result RAM write strobe.
- wr_addr, out, ADDR_W: result RAM write address.
- wr_data, out, SAMPLE_W: result RAM write data.
- busy, out, 1: run in progress.
- done, out, 1: run complete; held until the next start or rst.
- sat_count, out, ADDR_W: number of clipped samples this run; saturates at all-ones.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, sat_count=0; discard and sample counters cleared. A reset mid-run aborts the run; wr_en is low from the next edge.
- States:
  - IDLE: start=1 → DISCARD if DISCARD>0, else CAPTURE. On the transition: clear the sample index, sat_count and done; set busy=1.
  - DISCARD: each in_valid increments the discard counter, with no write. The in_valid that brings the count to DISCARD → CAPTURE.
  - CAPTURE: each in_valid produces exactly one write. The write of index DEPTH-1 → DONE.
  - DONE: busy=0, done=1; in_valid ignored. start=1 → same as from IDLE (done clears that edge).
- start while busy=1 is ignored. in_valid in IDLE is ignored.
- Arithmetic:
  - s = in_data >>> FRAC_SHIFT (arithmetic shift, floor rounding).
  - s > 2^(SAMPLE_W-1)-1 → wr_data = 32767; s < -2^(SAMPLE_W-1) → wr_data = -32768. Either case increments sat_count (unless already all-ones).
  - Otherwise wr_data = s[SAMPLE_W-1:0].
- Latency: in_valid accepted at edge n → wr_en=1 in the cycle after edge n, for exactly one cycle, with wr_addr = sample index and wr_data registered alongside.
- Back-to-back in_valid is supported: one write per cycle, no stalls, no drops.
- Addresses are strictly 0,1,…,DEPTH-1 with no wrap. The index never exceeds DEPTH-1; any in_valid after the last write is ignored.
- In-flight write at a state change: when start coincides with the final in_valid of DISCARD or with entry to DONE, the in-flight write still completes.
- Simultaneous events:
  - rst together with start: rst wins.
  - start in DONE together with in_valid: in_valid is ignored that cycle.
- busy rises the edge after start is accepted. It falls on the same edge that the last wr_en is issued (done rises on that edge too).

Decomposition:
- Package filter_pkg: SAMPLE_W, ADDR_W, ACC_W, DEPTH constants; SAMPLE_MAX/SAMPLE_MIN; writer state enum {IDLE, DISCARD, CAPTURE, DONE}.
- Sub-module `sat_scale` (combinational): in ACC_W, parameter FRAC_SHIFT → out SAMPLE_W plus a `clipped` flag. Reusable wherever `filtering` output is narrowed.
- The top-level block holds the FSM, counters and output registers.

Test Plan:
1. Basic scaling, DEPTH=4, DISCARD=0: start, then in_data = 5<<15, 7<<15, 0, 1<<15 on consecutive cycles → writes (addr,data) = (0,5),(1,7),(2,0),(3,1), one cycle after each input. done=1 and busy=0 after (3,1); sat_count=0.
2. Saturation and floor: in_data = 40000<<15 → 32767; -(40000<<15) → -32768; -(3<<15)-1 → -4 → sat_count=2.
3. Discard, DISCARD=4, DEPTH=2: six in_valid pulses with values 1..6 (<<15) → only (0,5),(1,6) written; no wr_en for the first four.
4. Gapped input, DEPTH=3: in_valid at cycles 0, 3, 4 → wr_en at cycles 1, 4, 5, addresses 0,1,2. A further in_valid after done → no write.
5. Control edge cases:
   - start while busy → no restart, addresses continue.
   - rst at sample 2 of DEPTH=8 → all outputs return to reset values; wr_en low next cycle.
   - A new start then rewrites from addr 0.
6. Full run, default parameters: 16384 inputs from the RAM reader path → last write at addr 16383, done=1, no write at any address ≥16384.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared constants and types for the filter result write path.
package filter_pkg;

  localparam int ACC_W      = 105;
  localparam int SAMPLE_W   = 16;
  localparam int ADDR_W     = 14;
  localparam int DEPTH      = 16384;
  localparam int FRAC_SHIFT = 15;
  localparam int DISCARD    = 0;

  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISCARD,
    ST_CAPTURE,
    ST_DONE
  } writer_state_t;

endpackage

// File: rtl/filter_result_writer_sat_scale.sv
// Combinational narrowing of a filter accumulator to a saturated signed sample.
module sat_scale #(
  parameter int ACC_W      = filter_pkg::ACC_W,
  parameter int SAMPLE_W   = filter_pkg::SAMPLE_W,
  parameter int FRAC_SHIFT = filter_pkg::FRAC_SHIFT
) (
  input  logic signed [ACC_W-1:0]    in_data,
  output logic        [SAMPLE_W-1:0] out_data,
  output logic                       clipped
);

  logic signed [ACC_W-1:0]      shifted;
  logic        [ACC_W-SAMPLE_W:0] upper;

  // Floor-shift, then clip when the bits above the sample are not a pure sign extension
  always_comb begin
    shifted  = in_data >>> FRAC_SHIFT;
    upper    = shifted[ACC_W-1:SAMPLE_W-1];
    clipped  = !((upper == '0) || (upper == '1));
    out_data = shifted[SAMPLE_W-1:0];
    if (clipped) begin
      if (shifted[ACC_W-1]) out_data = {1'b1, {(SAMPLE_W-1){1'b0}}};
      else                  out_data = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/filter_result_writer.sv
// Captures filter accumulator outputs, scales/saturates them and writes them
// sequentially into the result RAM for one run started by the controller.
module filter_result_writer #(
  parameter int ACC_W      = filter_pkg::ACC_W,
  parameter int SAMPLE_W   = filter_pkg::SAMPLE_W,
  parameter int ADDR_W     = filter_pkg::ADDR_W,
  parameter int DEPTH      = filter_pkg::DEPTH,
  parameter int FRAC_SHIFT = filter_pkg::FRAC_SHIFT,
  parameter int DISCARD    = filter_pkg::DISCARD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic signed [ACC_W-1:0] in_data,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [SAMPLE_W-1:0]     wr_data,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       sat_count
);

  import filter_pkg::*;

  localparam int                DISC_W    = (DISCARD > 1) ? $clog2(DISCARD + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [DISC_W-1:0] LAST_DISC = DISC_W'((DISCARD > 0) ? DISCARD - 1 : 0);

  writer_state_t        state;
  logic [ADDR_W-1:0]    idx;
  logic [DISC_W-1:0]    disc_cnt;
  logic [SAMPLE_W-1:0]  scaled;
  logic                 clipped;

  sat_scale #(
    .ACC_W      (ACC_W),
    .SAMPLE_W   (SAMPLE_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_sat_scale (
    .in_data  (in_data),
    .out_data (scaled),
    .clipped  (clipped)
  );

  // Run FSM with counters and registered RAM-write / status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      disc_cnt  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat_count <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          // in_valid is ignored here, including when it coincides with start
          if (start) begin
            state     <= (DISCARD > 0) ? ST_DISCARD : ST_CAPTURE;
            idx       <= '0;
            disc_cnt  <= '0;
            sat_count <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_DISCARD: begin
          if (in_valid) begin
            if (disc_cnt == LAST_DISC) state <= ST_CAPTURE;
            disc_cnt <= disc_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (in_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= idx;
            wr_data <= scaled;
            if (clipped && (sat_count != '1)) sat_count <= sat_count + 1'b1;
            // busy/done flip on the same edge that issues the final write
            if (idx == LAST_IDX) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_result_writer.sv
// Self-checking bench: five writer instances with different DEPTH/DISCARD
// share one input stream; a queue-based run model predicts every write.
module tb_filter_result_writer;

  localparam int NI = 5;
  localparam int DEP [NI] = '{4, 2, 8, 16384, 3};
  localparam int DIS [NI] = '{0, 4, 0, 0, 0};

  logic clk, rst, in_valid;
  logic signed [104:0] in_data;
  logic [NI-1:0] start_v, wr_en_v, busy_v, done_v;
  logic [NI-1:0][13:0] wr_addr_v, sat_v;
  logic [NI-1:0][15:0] wr_data_v;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 0;

  typedef struct { int cyc; int addr; logic signed [15:0] data; } exp_t;
  exp_t q [NI][$];
  bit act [NI];
  bit fin [NI];
  int cnt [NI];
  int msat [NI];

  typedef struct { logic signed [104:0] din; logic signed [15:0] exp; bit clip; } vec_t;
  vec_t tbl [8];

  filter_result_writer #(.DEPTH(4), .DISCARD(0)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid), .in_data(in_data),
    .wr_en(wr_en_v[0]), .wr_addr(wr_addr_v[0]), .wr_data(wr_data_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .sat_count(sat_v[0]));
  filter_result_writer #(.DEPTH(2), .DISCARD(4)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid), .in_data(in_data),
    .wr_en(wr_en_v[1]), .wr_addr(wr_addr_v[1]), .wr_data(wr_data_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .sat_count(sat_v[1]));
  filter_result_writer #(.DEPTH(8), .DISCARD(0)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid), .in_data(in_data),
    .wr_en(wr_en_v[2]), .wr_addr(wr_addr_v[2]), .wr_data(wr_data_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .sat_count(sat_v[2]));
  filter_result_writer u_d (
    .clk(clk), .rst(rst), .start(start_v[3]), .in_valid(in_valid), .in_data(in_data),
    .wr_en(wr_en_v[3]), .wr_addr(wr_addr_v[3]), .wr_data(wr_data_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .sat_count(sat_v[3]));
  filter_result_writer #(.DEPTH(3), .DISCARD(0)) u_e (
    .clk(clk), .rst(rst), .start(start_v[4]), .in_valid(in_valid), .in_data(in_data),
    .wr_en(wr_en_v[4]), .wr_addr(wr_addr_v[4]), .wr_data(wr_data_v[4]),
    .busy(busy_v[4]), .done(done_v[4]), .sat_count(sat_v[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(actual), $signed(expected));
    end
  endtask

  // Sample = floor(acc / 2^15), clamped to the signed 16-bit range
  function automatic void ref_scale(input logic signed [104:0] acc,
                                    output logic signed [15:0] o, output bit c);
    logic signed [104:0] s;
    s = acc >>> 15;
    c = 1'b1;
    if (s > 105'sd32767)       o = 16'sd32767;
    else if (s < -105'sd32768) o = -16'sd32768;
    else begin o = s[15:0]; c = 1'b0; end
  endfunction

  function automatic logic signed [104:0] rnd();
    logic [31:0] r;
    logic signed [104:0] v;
    r = $urandom;
    v = {{73{r[31]}}, r};
    return v <<< $urandom_range(0, 40);
  endfunction

  // Run model: counts accepted inputs per run and predicts each write
  always @(posedge clk) begin
    logic signed [15:0] d;
    bit c;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        act[k] = 1'b0; fin[k] = 1'b0; msat[k] = 0; cnt[k] = 0;
        q[k].delete();
      end else if (start_v[k] && !act[k]) begin
        act[k] = 1'b1; fin[k] = 1'b0; cnt[k] = 0; msat[k] = 0;
      end else if (act[k] && in_valid) begin
        if (cnt[k] >= DIS[k]) begin
          ref_scale(in_data, d, c);
          q[k].push_back('{cyc + 1, cnt[k] - DIS[k], d});
          if (c && msat[k] < 16383) msat[k]++;
        end
        cnt[k]++;
        if (cnt[k] == DIS[k] + DEP[k]) begin act[k] = 1'b0; fin[k] = 1'b1; end
      end
    end
    cyc++;
  end

  // Compare every instance against the model between clock edges
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int k = 0; k < NI; k++) begin
        if (wr_en_v[k]) begin
          if (q[k].size() == 0) begin
            chk($sformatf("unexpected_write[%0d]", k), 64'(wr_en_v[k]), 64'd0);
          end else begin
            e = q[k].pop_front();
            chk($sformatf("write_cycle[%0d]", k), 64'(cyc), 64'(e.cyc));
            chk($sformatf("wr_addr[%0d]", k), 64'(wr_addr_v[k]), 64'(e.addr));
            chk($sformatf("wr_data[%0d]", k), 64'($signed(wr_data_v[k])), 64'(e.data));
          end
        end else if (q[k].size() > 0 && q[k][0].cyc <= cyc) begin
          chk($sformatf("missing_write[%0d]", k), 64'(wr_en_v[k]), 64'd1);
          void'(q[k].pop_front());
        end
        chk($sformatf("busy[%0d]", k), 64'(busy_v[k]), 64'(act[k]));
        chk($sformatf("done[%0d]", k), 64'(done_v[k]), 64'(fin[k]));
        chk($sformatf("sat_count[%0d]", k), 64'(sat_v[k]), 64'(msat[k]));
      end
    end
  end

  task automatic go(input int k);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  task automatic send(input logic signed [104:0] v);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_wr_en[%0d]", k), 64'(wr_en_v[k]), 64'd0);
      chk($sformatf("rst_wr_addr[%0d]", k), 64'(wr_addr_v[k]), 64'd0);
      chk($sformatf("rst_wr_data[%0d]", k), 64'(wr_data_v[k]), 64'd0);
      chk($sformatf("rst_busy[%0d]", k), 64'(busy_v[k]), 64'd0);
      chk($sformatf("rst_done[%0d]", k), 64'(done_v[k]), 64'd0);
      chk($sformatf("rst_sat[%0d]", k), 64'(sat_v[k]), 64'd0);
    end
  endtask

  initial begin
    int nclip;
    rst = 1'b1; start_v = '0; in_valid = 1'b0; in_data = '0;

    tbl[0] = '{-(105'sd32768 << 15),          -16'sd32768, 1'b0};
    tbl[1] = '{105'sd40000 << 15,              16'sd32767, 1'b1};
    tbl[2] = '{-(105'sd40000 << 15),          -16'sd32768, 1'b1};
    tbl[3] = '{-(105'sd3 << 15) - 105'sd1,    -16'sd4,     1'b0};
    tbl[4] = '{105'sd32767 << 15,              16'sd32767, 1'b0};
    tbl[5] = '{105'sd32768 << 15,              16'sd32767, 1'b1};
    tbl[6] = '{-(105'sd32769 << 15),          -16'sd32768, 1'b1};
    tbl[7] = '{-105'sd1,                      -16'sd1,     1'b0};

    idle(3);
    check_reset_all();
    rst = 1'b0;
    mon_en = 1'b1;

    // Basic scaling, DEPTH=4
    go(0);
    send(105'sd5 << 15); send(105'sd7 << 15); send(105'sd0); send(105'sd1 << 15);
    chk("t1_last_addr", 64'(wr_addr_v[0]), 64'd3);
    chk("t1_last_data", 64'(wr_data_v[0]), 64'd1);
    chk("t1_done", 64'(done_v[0]), 64'd1);
    chk("t1_busy", 64'(busy_v[0]), 64'd0);
    chk("t1_sat", 64'(sat_v[0]), 64'd0);

    // Saturation / floor vectors, DEPTH=8
    go(2);
    nclip = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = tbl[i].din;
      @(negedge clk);
      if (tbl[i].clip) nclip++;
      chk($sformatf("tbl_wr_en[%0d]", i), 64'(wr_en_v[2]), 64'd1);
      chk($sformatf("tbl_addr[%0d]", i), 64'(wr_addr_v[2]), 64'(i));
      chk($sformatf("tbl_data[%0d]", i), 64'($signed(wr_data_v[2])), 64'(tbl[i].exp));
    end
    in_valid = 1'b0;
    chk("tbl_sat_count", 64'(sat_v[2]), 64'(nclip));
    chk("tbl_done", 64'(done_v[2]), 64'd1);

    // Discard 4 leading outputs, DEPTH=2
    go(1);
    for (int v = 1; v <= 6; v++) send(105'(v) << 15);
    chk("disc_last_addr", 64'(wr_addr_v[1]), 64'd1);
    chk("disc_last_data", 64'(wr_data_v[1]), 64'd6);
    idle(2);

    // Gapped input then a stray input after done, DEPTH=3
    go(4);
    send(105'sd11 << 15); idle(2); send(105'sd12 << 15); send(105'sd13 << 15);
    chk("gap_done", 64'(done_v[4]), 64'd1);
    idle(1); send(105'sd14 << 15); idle(2);

    // Start while busy, then reset mid-run, then a fresh run
    go(2);
    send(rnd()); send(rnd());
    start_v[2] = 1'b1; send(rnd()); start_v[2] = 1'b0;
    send(rnd());
    rst = 1'b1; in_valid = 1'b1; in_data = rnd();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check_reset_all();
    go(2);
    for (int i = 0; i < 8; i++) begin
      send(rnd());
      chk($sformatf("rerun_addr[%0d]", i), 64'(wr_addr_v[2]), 64'(i));
    end

    // Randomized traffic across all short instances
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 149) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = rnd();
      for (int k = 0; k < NI; k++)
        start_v[k] = (k != 3) && ($urandom_range(0, 11) == 0);
      @(negedge clk);
    end
    rst = 1'b0; in_valid = 1'b0; start_v = '0;
    idle(2);

    // Full default-size run
    rst = 1'b1; idle(1); rst = 1'b0;
    go(3);
    for (int i = 0; i < 16384; i++) send(rnd());
    chk("full_last_addr", 64'(wr_addr_v[3]), 64'd16383);
    chk("full_done", 64'(done_v[3]), 64'd1);
    send(rnd()); send(rnd()); idle(3);

    for (int k = 0; k < NI; k++)
      chk($sformatf("pending_writes[%0d]", k), 64'(q[k].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
